// File: rtl/touch_key_array.sv
// Multi-channel capacitive touch-key front end: synchronise, debounce, detect press/long-hold,
// and drive one LED per channel in toggle, momentary, long-press-toggle or freeze mode.
module touch_key_array #(
    parameter int N_CH     = 4,
    parameter int DEB_CYC  = 500000,
    parameter int LONG_CYC = 50000000,
    parameter bit ACT_LOW  = 1'b1
) (
    input  logic            sys_clk,
    input  logic            rst,
    input  logic [N_CH-1:0] key_in,
    input  logic [1:0]      mode,
    output logic [N_CH-1:0] led,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] long_pulse
);

    localparam int DW = $clog2(DEB_CYC);
    localparam int HW = $clog2(LONG_CYC + 1);
    localparam logic [DW-1:0]   DEB_LAST = DW'(DEB_CYC - 1);
    localparam logic [HW-1:0]   HOLD_MAX = HW'(LONG_CYC);
    localparam logic [N_CH-1:0] IDLE_LVL = {N_CH{ACT_LOW}};

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_MOMENT = 2'b01,
        MODE_LONG   = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_e;

    mode_e modeSel;
    assign modeSel = mode_e'(mode);

    logic [N_CH-1:0] sync1_q, sync2_q;
    logic [N_CH-1:0] deb_q, deb_d;
    logic [N_CH-1:0] debDly_q;
    logic [N_CH-1:0] hit_q, hit_d;
    logic [N_CH-1:0] press_q, press_d;
    logic [N_CH-1:0] long_q, long_d;
    logic [N_CH-1:0] led_q, led_d;
    logic [N_CH-1:0] touched;
    logic [DW-1:0]   dcnt_q [N_CH];
    logic [DW-1:0]   dcnt_d [N_CH];
    logic [HW-1:0]   hcnt_q [N_CH];
    logic [HW-1:0]   hcnt_d [N_CH];

    assign touched = sync2_q ^ IDLE_LVL;

    always_comb begin
        deb_d = deb_q;
        hit_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            dcnt_d[i] = '0;
            hcnt_d[i] = '0;
            // A level must disagree with deb for DEB_CYC consecutive cycles before it is accepted
            if (touched[i] != deb_q[i]) begin
                if (dcnt_q[i] == DEB_LAST) begin
                    deb_d[i] = touched[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DW'(1);
                end
            end
            if (deb_q[i]) begin
                hcnt_d[i] = (hcnt_q[i] == HOLD_MAX) ? hcnt_q[i] : hcnt_q[i] + HW'(1);
            end
            hit_d[i] = (hcnt_q[i] == HOLD_MAX);
        end
        press_d = deb_q & ~debDly_q;
        long_d  = hit_d & ~hit_q;
        case (modeSel)
            MODE_TOGGLE: led_d = led_q ^ press_d;
            MODE_MOMENT: led_d = deb_q;
            MODE_LONG:   led_d = led_q ^ long_d;
            default:     led_d = led_q;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= IDLE_LVL;
            sync2_q  <= IDLE_LVL;
            deb_q    <= '0;
            debDly_q <= '0;
            hit_q    <= '0;
            press_q  <= '0;
            long_q   <= '0;
            led_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                dcnt_q[i] <= '0;
                hcnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= key_in;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            debDly_q <= deb_q;
            hit_q    <= hit_d;
            press_q  <= press_d;
            long_q   <= long_d;
            led_q    <= led_d;
            for (int i = 0; i < N_CH; i++) begin
                dcnt_q[i] <= dcnt_d[i];
                hcnt_q[i] <= hcnt_d[i];
            end
        end
    end

    assign led         = led_q;
    assign press_pulse = press_q;
    assign long_pulse  = long_q;

endmodule

// File: tb/tb_touch_key_array.sv
// Scoreboard bench for touch_key_array: a cycle-level reference model predicts outputs,
// a monitor process pops and compares them after every clock edge or reset assertion.
module tb_touch_key_array;

    localparam int N_CH     = 4;
    localparam int DEB_CYC  = 8;
    localparam int LONG_CYC = 40;
    localparam bit ACT_LOW  = 1'b1;

    logic            sys_clk = 1'b0;
    logic            rst     = 1'b0;
    logic [N_CH-1:0] key_in  = {N_CH{ACT_LOW}};
    logic [1:0]      mode    = 2'b00;
    logic [N_CH-1:0] led, press_pulse, long_pulse;

    touch_key_array #(
        .N_CH(N_CH), .DEB_CYC(DEB_CYC), .LONG_CYC(LONG_CYC), .ACT_LOW(ACT_LOW)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .key_in(key_in), .mode(mode),
        .led(led), .press_pulse(press_pulse), .long_pulse(long_pulse)
    );

    always #10 sys_clk = ~sys_clk;

    typedef struct {
        bit              atReset;
        logic [N_CH-1:0] press;
        logic [N_CH-1:0] lng;
        logic [N_CH-1:0] led;
    } exp_t;

    exp_t scoreQ[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference model: deb flips once the last DEB_CYC synchronised samples all disagree with it;
    // holdRun counts how many consecutive cycles deb has been 1.
    logic [N_CH-1:0] touchHist[$];
    bit   [N_CH-1:0] mDeb;
    bit   [N_CH-1:0] mLed;
    int              holdRun1 [N_CH];
    int              holdRun2 [N_CH];
    int              edgeN;

    task automatic modelClear();
        touchHist.delete();
        mDeb  = '0;
        mLed  = '0;
        edgeN = 0;
        for (int c = 0; c < N_CH; c++) begin
            holdRun1[c] = 0;
            holdRun2[c] = 0;
        end
    endtask

    task automatic modelStep(input logic [N_CH-1:0] touch, input logic [1:0] md);
        exp_t e;
        bit   flip, s, p, l;
        touchHist.push_back(touch);
        e.atReset = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            flip = 1'b1;
            for (int j = edgeN - DEB_CYC + 1; j <= edgeN; j++) begin
                s = (j >= 2) ? touchHist[j-2][c] : 1'b0;
                if (s == mDeb[c]) flip = 1'b0;
            end
            p = (holdRun1[c] == 1);
            l = (holdRun2[c] == LONG_CYC);
            case (md)
                2'b00:   mLed[c] = mLed[c] ^ p;
                2'b01:   mLed[c] = mDeb[c];
                2'b10:   mLed[c] = mLed[c] ^ l;
                default: mLed[c] = mLed[c];
            endcase
            if (flip) mDeb[c] = ~mDeb[c];
            holdRun2[c] = holdRun1[c];
            holdRun1[c] = mDeb[c] ? holdRun1[c] + 1 : 0;
            e.press[c] = p;
            e.lng[c]   = l;
        end
        e.led = mLed;
        scoreQ.push_back(e);
        edgeN++;
    endtask

    task automatic applyStimulus(input logic [N_CH-1:0] touch, input logic [1:0] md, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            key_in = ACT_LOW ? ~touch : touch;
            mode   = md;
            modelStep(touch, md);
            @(negedge sys_clk);
        end
    endtask

    task automatic applyReset(input int holdCycles);
        exp_t e;
        e.atReset = 1'b1;
        e.press   = '0;
        e.lng     = '0;
        e.led     = '0;
        scoreQ.push_back(e);
        rst = 1'b1;
        modelClear();
        repeat (holdCycles) @(negedge sys_clk);
        rst = 1'b0;
    endtask

    task automatic checkOutput(input exp_t e);
        vectors++;
        if (press_pulse !== e.press || long_pulse !== e.lng || led !== e.led) begin
            miscompares++;
            $display("[TB] FAIL outputs t=%0t rst=%b: press %b exp %b, long %b exp %b, led %b exp %b",
                     $time, rst, press_pulse, e.press, long_pulse, e.lng, led, e.led);
        end
    endtask

    // Monitor: each clock edge (or reset assertion) presents a fresh output word to compare
    always @(posedge sys_clk or posedge rst) begin
        #1;
        if (scoreQ.size() > 0 && scoreQ[0].atReset == rst) begin
            checkOutput(scoreQ.pop_front());
        end
    end

    initial begin
        logic [N_CH-1:0] cur;
        logic [1:0]      md;

        applyReset(3);

        // Toggle mode: two touches on ch0 toggle led on then off
        applyStimulus(4'b0000, 2'b00, 4);
        applyStimulus(4'b0001, 2'b00, 20);
        applyStimulus(4'b0000, 2'b00, 20);
        applyStimulus(4'b0001, 2'b00, 20);
        applyStimulus(4'b0000, 2'b00, 20);

        // Glitch rejection on ch1, then a touch exactly DEB_CYC cycles long
        applyStimulus(4'b0010, 2'b00, 5);
        applyStimulus(4'b0000, 2'b00, 15);
        applyStimulus(4'b0010, 2'b00, DEB_CYC);
        applyStimulus(4'b0000, 2'b00, 20);
        applyStimulus(4'b0010, 2'b00, DEB_CYC - 1);
        applyStimulus(4'b0000, 2'b00, 20);

        // Long-press mode on ch2: 60-cycle hold toggles, 30-cycle hold does not
        applyStimulus(4'b0100, 2'b10, 60);
        applyStimulus(4'b0000, 2'b10, 20);
        applyStimulus(4'b0100, 2'b10, 30);
        applyStimulus(4'b0000, 2'b10, 20);

        // Momentary mode on ch3
        applyStimulus(4'b1000, 2'b01, 20);
        applyStimulus(4'b0000, 2'b01, 20);

        // All channels together, then freeze with a ch0 touch
        applyStimulus(4'b1111, 2'b00, 20);
        applyStimulus(4'b0000, 2'b00, 20);
        applyStimulus(4'b0001, 2'b11, 20);
        applyStimulus(4'b0000, 2'b11, 20);

        // Reset mid-hold with key kept touched through release
        applyStimulus(4'b0001, 2'b00, DEB_CYC + 2 + 20);
        applyReset(2);
        applyStimulus(4'b0001, 2'b00, 60);
        applyStimulus(4'b0000, 2'b00, 20);

        // Randomised activity; higher channels change less often to reach long holds
        cur = '0;
        md  = 2'b00;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 5 + 12 * c) == 0) cur[c] = ~cur[c];
            end
            if ($urandom_range(0, 79) == 0) md = 2'($urandom_range(0, 3));
            if (i == 400) applyReset(2);
            applyStimulus(cur, md, 1);
        end
        applyStimulus(4'b0000, md, 20);

        repeat (2) @(negedge sys_clk);
        if (scoreQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain: %0d expected words left unchecked, required 0", scoreQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/touch_key_array.md
TOUCH_KEY_ARRAY -- requirements
Module: touch_key_array

Interface
REQ-001 Parameter N_CH, default 4, number of independent touch-key channels (1..16).
REQ-002 Parameter DEB_CYC, default 500000, debounce stability window in sys_clk cycles (>=2).
REQ-003 Parameter LONG_CYC, default 50000000, hold time in sys_clk cycles for a long press (>DEB_CYC).
REQ-004 Parameter ACT_LOW, default 1, 1 = key_in low means touched, 0 = key_in high means touched.
REQ-005 sys_clk  input  1  single clock; all state on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 key_in  input  N_CH  raw asynchronous touch-sensor levels, one bit per channel.
REQ-008 mode  input  2  global LED mode: 00 toggle, 01 momentary, 10 long-press toggle, 11 freeze.
REQ-009 led  output  N_CH  registered LED drive per channel, 1 = on.
REQ-010 press_pulse  output  N_CH  one-cycle pulse per debounced touch onset.
REQ-011 long_pulse  output  N_CH  one-cycle pulse when a touch has been held LONG_CYC cycles.

Function
REQ-012 Each channel SHALL pass key_in through a 2-flop synchroniser before any other logic; channels SHALL be fully independent.
REQ-013 Touched level t = sync XOR ACT_LOW... i.e. t = ~sync when ACT_LOW=1, t = sync when ACT_LOW=0.
REQ-014 Debounce: per-channel state deb and counter dcnt; dcnt clears in any cycle where t == deb, else increments.
REQ-015 When t != deb and dcnt == DEB_CYC-1, deb SHALL take t and dcnt SHALL clear in that same cycle.
REQ-016 Glitches shorter than DEB_CYC cycles (after synchroniser) SHALL NOT change deb.
REQ-017 press_pulse[i] SHALL be 1 for exactly the one cycle following deb[i] going 0->1; no pulse on release.
REQ-018 Hold counter hcnt[i] SHALL clear while deb[i]=0, increment while deb[i]=1, saturate at LONG_CYC.
REQ-019 long_pulse[i] SHALL be 1 for exactly the one cycle following hcnt[i] reaching LONG_CYC; at most one per press.
REQ-020 Release (deb 1->0) before LONG_CYC SHALL produce no long_pulse.
REQ-021 Mode 00: led[i] SHALL toggle in the cycle press_pulse[i] is asserted.
REQ-022 Mode 01: led[i] SHALL equal deb[i] delayed one cycle.
REQ-023 Mode 10: led[i] SHALL toggle in the cycle long_pulse[i] is asserted; press_pulse ignored for led.
REQ-024 Mode 11: led SHALL hold its value; press_pulse and long_pulse SHALL still be generated.
REQ-025 Mode change SHALL take effect the next cycle; led keeps its current value at the switch (momentary then follows deb).
REQ-026 Total latency from key_in edge to press_pulse SHALL be DEB_CYC+3 cycles (2 sync + DEB_CYC + 1 pulse register).
REQ-027 Counter widths SHALL be $clog2(DEB_CYC) and $clog2(LONG_CYC+1); no wrap-around permitted.

Reset
REQ-028 While rst=1, led, press_pulse, long_pulse SHALL be 0 immediately (asynchronously).
REQ-029 Reset SHALL set synchroniser flops to the untouched level (1 if ACT_LOW=1), deb=0, dcnt=0, hcnt=0.
REQ-030 A key held through reset release SHALL be treated as a new touch: press_pulse after DEB_CYC+3 cycles.
REQ-031 Reset asserted mid-debounce or mid-hold SHALL discard the partial count; no pulse generated.

Verification (DEB_CYC=8, LONG_CYC=40, N_CH=4, ACT_LOW=1, 20 ns clock)
REQ-032 Mode 00, key_in[0] low 20 cycles then high -> one press_pulse[0] 11 cycles after fall, led[0] 0->1; second touch -> led[0] 1->0.
REQ-033 key_in[1] low for 5 cycles -> no press_pulse[1], led[1] stays 0; low for exactly 8 synced cycles -> press_pulse.
REQ-034 Mode 10, key_in[2] low 60 cycles -> press_pulse then long_pulse 40 cycles later, single led[2] toggle; 30-cycle hold -> no long_pulse, no toggle.
REQ-035 Mode 01, key_in[3] low 20 cycles -> led[3]=1 from deb rise+1 until deb fall+1, then 0.
REQ-036 Simultaneous touches on all 4 channels in mode 00 -> four coincident press_pulses, led=4'b1111; mode 11 then touch ch0 -> press_pulse[0], led unchanged.
REQ-037 rst pulsed during ch0 hold at hcnt=20 -> outputs 0 at once; key still low after release -> press_pulse 11 cycles later, no stale long_pulse.
